// File: rtl/fft_frame_feeder_pkg.sv
// Shared types and default sizes for the FFT frame feeder.
// The state enum and bus widths are kept here so the top, its buffer and its bus agree.
package fft_frame_feeder_pkg;

   localparam int DEFAULT_FFT_LEN  = 2048;
   localparam int DEFAULT_SAMPLE_W = 16;
   localparam int FFT_DATA_W       = 32;
   localparam int FFT_REAL_W       = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      PAD    = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/fft_frame_feeder_if.sv
// AXI-Stream style beat bus between the frame feeder (master) and the FFT core (slave).
interface fft_frame_feeder_if;
   import fft_frame_feeder_pkg::*;

   logic [FFT_DATA_W-1:0] fft_data_out;
   logic                  fft_valid_out;
   logic                  fft_last_out;
   logic                  fft_ready_in;

   modport master (
      output fft_data_out,
      output fft_valid_out,
      output fft_last_out,
      input  fft_ready_in
   );

   modport slave (
      input  fft_data_out,
      input  fft_valid_out,
      input  fft_last_out,
      output fft_ready_in
   );

endinterface

// File: rtl/fft_frame_feeder_sample_fifo.sv
// Synchronous sample buffer. The head entry is read directly from the storage flops.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module sample_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [AW:0]      count_q, count_d;
   logic             doPush;
   logic             doPop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign data_o  = mem_q[rdPtr_q];
   assign doPop   = pop_i && !empty_o;
   assign doPush  = push_i && (!full_o || doPop);

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({doPush, doPop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; consumers only look at it while the buffer is non-empty.
   always_ff @(posedge clk_in) begin
      if (doPush) mem_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers a recording of audio samples and streams it to an FFT as whole frames,
// zero-padding the final frame so every frame carries exactly FFT_LEN beats.
module fft_frame_feeder
   import fft_frame_feeder_pkg::*;
#(
   parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
   parameter int FFT_LEN    = DEFAULT_FFT_LEN,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       start_in,
   input  logic [31:0]                recording_length,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic                       sample_valid_in,
   fft_frame_feeder_if.master         fft_bus,
   output logic                       busy_out,
   output logic                       done_out,
   output logic                       overflow_out,
   output logic [15:0]                frame_count_out
);

   localparam int IDX_W = $clog2(FFT_LEN);

   state_e             state_q, state_d;
   logic [31:0]        len_q, len_d;
   logic [31:0]        captured_q, captured_d;
   logic [IDX_W-1:0]   index_q, index_d;
   logic [15:0]        frame_q, frame_d;
   logic               overflow_q, overflow_d;
   logic               zeroDone_q, zeroDone_d;

   logic [FFT_REAL_W-1:0] sampleReal;
   logic [FFT_REAL_W-1:0] fifoHead;
   logic fifoFull, fifoEmpty;
   logic wantSample, popBeat, acceptSample, dropSample;
   logic validOut, lastOut, xfer;

   // The real part is exactly 16 bits wide: wider samples keep their low bits, narrower ones sign-extend.
   if (SAMPLE_W >= FFT_REAL_W) begin : g_trunc
      assign sampleReal = sample_in[FFT_REAL_W-1:0];
   end else begin : g_sext
      assign sampleReal = {{(FFT_REAL_W-SAMPLE_W){sample_in[SAMPLE_W-1]}}, sample_in};
   end

   sample_fifo #(
      .WIDTH (FFT_REAL_W),
      .DEPTH (FIFO_DEPTH)
   ) u_sample_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .push_i  (acceptSample),
      .data_i  (sampleReal),
      .pop_i   (popBeat),
      .data_o  (fifoHead),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   assign validOut     = ((state_q == STREAM) && !fifoEmpty) || (state_q == PAD);
   assign lastOut      = validOut && (index_q == IDX_W'(FFT_LEN - 1));
   assign xfer         = validOut && fft_bus.fft_ready_in;
   assign popBeat      = (state_q == STREAM) && xfer;
   assign wantSample   = (state_q == STREAM) && sample_valid_in && (captured_q < len_q);
   assign acceptSample = wantSample && (!fifoFull || popBeat);
   assign dropSample   = wantSample && fifoFull && !popBeat;

   assign fft_bus.fft_valid_out = validOut;
   assign fft_bus.fft_last_out  = lastOut;
   assign fft_bus.fft_data_out  = (state_q == STREAM)
                                ? {{(FFT_DATA_W-FFT_REAL_W){1'b0}}, fifoHead} : '0;
   assign busy_out        = (state_q != IDLE);
   assign done_out        = (state_q == DONE) || zeroDone_q;
   assign overflow_out    = overflow_q;
   assign frame_count_out = frame_q;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      captured_d = captured_q;
      index_d    = index_q;
      frame_d    = frame_q;
      overflow_d = overflow_q;
      zeroDone_d = 1'b0;

      if (xfer) begin
         index_d = lastOut ? '0 : index_q + 1'b1;
         if (lastOut && (frame_q != 16'hFFFF)) frame_d = frame_q + 16'd1;
      end

      case (state_q)
         IDLE: begin
            if (start_in) begin
               if (recording_length == 32'd0) begin
                  zeroDone_d = 1'b1;
               end else begin
                  state_d    = STREAM;
                  len_d      = recording_length;
                  captured_d = '0;
                  index_d    = '0;
                  frame_d    = '0;
                  overflow_d = 1'b0;
               end
            end
         end
         STREAM: begin
            if (acceptSample) captured_d = captured_q + 32'd1;
            if (dropSample)   overflow_d = 1'b1;
            // An empty buffer means no beat moves this cycle, so index_q is final here.
            if ((captured_q == len_q) && fifoEmpty) begin
               state_d = (index_q == '0) ? DONE : PAD;
            end
         end
         PAD: begin
            if (xfer && lastOut) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         len_q      <= '0;
         captured_q <= '0;
         index_q    <= '0;
         frame_q    <= '0;
         overflow_q <= 1'b0;
         zeroDone_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         captured_q <= captured_d;
         index_q    <= index_d;
         frame_q    <= frame_d;
         overflow_q <= overflow_d;
         zeroDone_q <= zeroDone_d;
      end
   end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder: table of recording scenarios driven with random
// samples/backpressure and compared cycle by cycle against a queue-based reference model.
module tb_fft_frame_feeder;

   localparam int FFT_LEN    = 2048;
   localparam int FIFO_DEPTH = 16;

   typedef struct {
      int len;
      int period;
      int readyPct;
      int stallAt;
      int stallLen;
      int startAgainAt;
      int expBeats;
      int expFrames;
      int expOvf;
   } vec_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               startIn;
   logic [31:0]        recLen;
   logic signed [15:0] sampleIn;
   logic               sampleValid;
   logic               busy;
   logic               done;
   logic               ovf;
   logic [15:0]        frameCount;

   int assertCount = 0;
   int failCount   = 0;
   int scenFails   = 0;

   vec_t vecs [7];
   vec_t postReset;

   always #5 clk = ~clk;

   fft_frame_feeder_if fftBus ();

   fft_frame_feeder #(
      .SAMPLE_W   (16),
      .FFT_LEN    (FFT_LEN),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk_in           (clk),
      .rst_in           (rst),
      .start_in         (startIn),
      .recording_length (recLen),
      .sample_in        (sampleIn),
      .sample_valid_in  (sampleValid),
      .fft_bus          (fftBus),
      .busy_out         (busy),
      .done_out         (done),
      .overflow_out     (ovf),
      .frame_count_out  (frameCount)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         scenFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".data"},  fftBus.fft_data_out, 32'h0);
      checkOutput({tag, ".valid"}, 32'(fftBus.fft_valid_out), 32'h0);
      checkOutput({tag, ".last"},  32'(fftBus.fft_last_out), 32'h0);
      checkOutput({tag, ".busy"},  32'(busy), 32'h0);
      checkOutput({tag, ".done"},  32'(done), 32'h0);
      checkOutput({tag, ".ovf"},   32'(ovf), 32'h0);
      checkOutput({tag, ".frame"}, 32'(frameCount), 32'h0);
   endtask

   // One recording: the model tracks a phase, a sample queue, and beat/frame totals.
   task automatic applyStimulus(input vec_t v);
      logic [15:0] q [$];
      int phase = 0;
      int captured = 0, beats = 0, frames = 0, limit = 0;
      bit mOvf = 0, zeroDone = 0, finished = 0;
      bit eValid, eLast, eDone, xfer, endNow;
      logic [31:0] eData;
      int dBeats = 0, dLasts = 0, lastBad = 0, padBad = 0, donePulses = 0;
      int budget = (v.len * v.period + 2 * FFT_LEN) * 3 + 1000;
      scenFails = 0;
      for (int c = 0; c < budget && !finished && scenFails <= 8; c++) begin
         startIn     = (c == 0) || (v.startAgainAt != 0 && c == v.startAgainAt);
         recLen      = v.len;
         sampleValid = ((c % v.period) == 0);
         sampleIn    = 16'($urandom);
         fftBus.fft_ready_in = ($urandom_range(99) < v.readyPct) &&
                               !(v.stallLen > 0 && c >= v.stallAt && c < v.stallAt + v.stallLen);
         #1;
         eValid = (phase == 1 && q.size() > 0) || phase == 2;
         eLast  = eValid && ((beats % FFT_LEN) == FFT_LEN - 1);
         eDone  = (phase == 3) || zeroDone;
         eData  = (phase == 1 && q.size() > 0) ? {16'h0, q[0]} : 32'h0;
         checkOutput("busy",  32'(busy), 32'(phase != 0));
         checkOutput("done",  32'(done), 32'(eDone));
         checkOutput("valid", 32'(fftBus.fft_valid_out), 32'(eValid));
         checkOutput("last",  32'(fftBus.fft_last_out), 32'(eLast));
         if (eValid) checkOutput("data", fftBus.fft_data_out, eData);
         if (phase != 0) begin
            checkOutput("overflow", 32'(ovf), 32'(mOvf));
            checkOutput("frameCount", 32'(frameCount), 32'(frames));
         end
         if (done) donePulses++;
         if (fftBus.fft_valid_out && fftBus.fft_ready_in) begin
            if (fftBus.fft_last_out != ((dBeats % FFT_LEN) == FFT_LEN - 1)) lastBad++;
            if (dBeats >= v.len && fftBus.fft_data_out != 32'h0) padBad++;
            if (fftBus.fft_last_out) dLasts++;
            dBeats++;
         end

         xfer     = eValid && fftBus.fft_ready_in;
         zeroDone = 0;
         case (phase)
            0: if (startIn) begin
               if (v.len == 0) zeroDone = 1;
               else begin
                  phase = 1; captured = 0; beats = 0; frames = 0; mOvf = 0; limit = v.len;
               end
            end
            1: begin
               endNow = (captured == limit) && (q.size() == 0);
               if (xfer) void'(q.pop_front());
               if (sampleValid && captured < limit) begin
                  if (q.size() < FIFO_DEPTH) begin
                     q.push_back(sampleIn);
                     captured++;
                  end else mOvf = 1;
               end
               if (endNow) phase = ((beats % FFT_LEN) == 0) ? 3 : 2;
            end
            2: if (xfer && eLast) phase = 3;
            default: begin phase = 0; finished = 1; end
         endcase
         if (xfer) begin
            if (eLast && frames < 65535) frames++;
            beats++;
         end
         tick();
      end
      startIn = 0; sampleValid = 0; fftBus.fft_ready_in = 1;
      #1;
      checkOutput("finished", 32'(finished), 32'h1);
      checkOutput("beatCount", 32'(dBeats), 32'(v.expBeats));
      checkOutput("lastCount", 32'(dLasts), 32'(v.expFrames));
      checkOutput("lastPlacement", 32'(lastBad), 32'h0);
      checkOutput("padZeros", 32'(padBad), 32'h0);
      checkOutput("finalFrameCount", 32'(frameCount), 32'(v.expFrames));
      checkOutput("donePulses", 32'(donePulses), 32'h1);
      checkOutput("doneLow", 32'(done), 32'h0);
      checkOutput("idleAfterDone", 32'(busy), 32'h0);
      if (v.expOvf < 2) checkOutput("finalOverflow", 32'(ovf), 32'(v.expOvf));
      if (!finished) begin
         rst = 1; tick(); rst = 0;
      end
   endtask

   task automatic zeroLengthStart();
      startIn = 1; recLen = 0; sampleValid = 0;
      tick();
      startIn = 0;
      #1;
      checkOutput("zeroLen.done", 32'(done), 32'h1);
      checkOutput("zeroLen.busy", 32'(busy), 32'h0);
      checkOutput("zeroLen.valid", 32'(fftBus.fft_valid_out), 32'h0);
      tick();
      checkOutput("zeroLen.doneLow", 32'(done), 32'h0);
      checkOutput("zeroLen.busyLow", 32'(busy), 32'h0);
      checkOutput("zeroLen.noBeat", 32'(fftBus.fft_valid_out), 32'h0);
   endtask

   // Reset lands while beat 1000 of frame 0 is on the bus, together with start and a sample.
   task automatic resetMidFrame();
      int cnt = 0;
      recLen = 5000; sampleValid = 1; fftBus.fft_ready_in = 1;
      for (int c = 0; c < 3000 && cnt < 1000; c++) begin
         startIn  = (c == 0);
         sampleIn = 16'($urandom);
         #1;
         if (fftBus.fft_valid_out && fftBus.fft_ready_in) cnt++;
         tick();
      end
      checkOutput("reachBeat1000", 32'(cnt), 32'd1000);
      rst = 1; startIn = 1; sampleValid = 1;
      tick();
      rst = 0; startIn = 0; sampleValid = 0;
      #1;
      checkAllZero("midReset");
      tick();
      checkOutput("midReset.stillIdle", 32'(busy), 32'h0);
   endtask

   initial begin
      vecs[0] = '{4096, 1, 100, 0, 0,  0,   4096, 2, 0};
      vecs[1] = '{6250, 4, 100, 0, 0,  0,   8192, 4, 0};
      vecs[2] = '{100,  1, 100, 3, 40, 0,   2048, 1, 1};
      vecs[3] = '{1500, 1, 100, 0, 0,  200, 2048, 1, 0};
      vecs[4] = '{2048, 2, 100, 0, 0,  0,   2048, 1, 0};
      vecs[5] = '{1000, 3, 70,  0, 0,  0,   2048, 1, 2};
      vecs[6] = '{1,    1, 50,  0, 0,  0,   2048, 1, 0};
      postReset = '{300, 1, 100, 0, 0, 0, 2048, 1, 0};

      rst = 1; startIn = 0; recLen = 0; sampleIn = 0; sampleValid = 0;
      fftBus.fft_ready_in = 1;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst = 0;
      tick();

      for (int i = 0; i < 7; i++) begin
         $display("[TB] scenario %0d: length %0d, sample period %0d", i, vecs[i].len, vecs[i].period);
         applyStimulus(vecs[i]);
         tick();
      end

      zeroLengthStart();
      resetMidFrame();
      applyStimulus(postReset);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #6000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
